// File: rtl/pe_pkg.sv
// pe_pkg: shared packet type, route select encoding and address field defaults for the PE datapath
package pe_pkg;
  localparam int PKT_W = 8;
  localparam int ADDR_LSB_D = 4;
  localparam int ADDR_W_D = 4;
  typedef logic [PKT_W-1:0] pkt_t;
  typedef enum logic {SEL_LOCAL = 1'b0, SEL_FWD = 1'b1} route_sel_e;
endpackage

// File: rtl/pe_route_sel_fifo.sv
// sync_fifo: count-based synchronous FIFO; read data is the head entry, forced to 0 when empty
module sync_fifo #(
  parameter int W = 9,
  parameter int DEPTH = 4
)(
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (wr_en) r_wptr <= r_wptr + 1'b1;
      if (rd_en) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) r_mem[r_wptr] <= wr_data;
  end
  assign full    = r_count == (AW+1)'(DEPTH);
  assign empty   = r_count == '0;
  assign rd_data = empty ? '0 : r_mem[r_rptr];
endmodule

// File: rtl/pe_route_sel.sv
// pe_route_sel: buffered ingress that tags each packet local/forward by destination address.
// Define ROUTE_SEL_STATS_EN to add per-route pop counters cnt_local/cnt_fwd.
module pe_route_sel import pe_pkg::*; #(
  parameter int WIDTH      = PKT_W,
  parameter int ADDR_LSB   = ADDR_LSB_D,
  parameter int ADDR_W     = ADDR_W_D,
  parameter int LOCAL_ADDR = 0,
  parameter int DEPTH      = 4
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sel
`ifdef ROUTE_SEL_STATS_EN
  ,
  output logic [15:0]      cnt_local,
  output logic [15:0]      cnt_fwd
`endif
);
  localparam logic [ADDR_W-1:0] LOCAL = ADDR_W'(LOCAL_ADDR);
  route_sel_e     w_sel;
  logic           w_full, w_empty, w_push, w_pop;
  logic [WIDTH:0] w_head;
  assign w_sel     = (in_data[ADDR_LSB +: ADDR_W] != LOCAL) ? SEL_FWD : SEL_LOCAL;
  // held low through reset so nothing is accepted before the FIFO is live
  assign in_ready  = !rst && !w_full;
  assign out_valid = !w_empty;
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign out_sel   = w_head[WIDTH];
  assign out_data  = w_head[WIDTH-1:0];
  sync_fifo #(.W(WIDTH + 1), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_push),
    .wr_data ({1'(w_sel), in_data}),
    .rd_en   (w_pop),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty)
  );
`ifdef ROUTE_SEL_STATS_EN
  logic [15:0] r_cnt_local, r_cnt_fwd;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt_local <= '0;
      r_cnt_fwd   <= '0;
    end else if (w_pop) begin
      if (out_sel) r_cnt_fwd <= r_cnt_fwd + 16'd1;
      else         r_cnt_local <= r_cnt_local + 16'd1;
    end
  end
  assign cnt_local = r_cnt_local;
  assign cnt_fwd   = r_cnt_fwd;
`endif
endmodule

// File: tb/tb_pe_route_sel.sv
// tb_pe_route_sel: directed checks of routing, back-pressure, full/pop interplay, wrap and mid-stream reset
module tb_pe_route_sel;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_sel;
  int         n_chk = 0;
  int         n_err = 0;
  int         exp_local = 0;
  int         exp_fwd = 0;
`ifdef ROUTE_SEL_STATS_EN
  logic [15:0] cnt_local, cnt_fwd;
`endif

  pe_route_sel #(.WIDTH(8), .ADDR_LSB(4), .ADDR_W(4), .LOCAL_ADDR(3), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
`ifdef ROUTE_SEL_STATS_EN
    ,
    .cnt_local (cnt_local),
    .cnt_fwd   (cnt_fwd)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_stats(input string tag);
`ifdef ROUTE_SEL_STATS_EN
    chk({tag, "_local"}, 32'(cnt_local), 32'(exp_local));
    chk({tag, "_fwd"}, 32'(cnt_fwd), 32'(exp_fwd));
`endif
  endtask

  function automatic logic [8:0] entry(input logic [7:0] d);
    return {d[7:4] != 4'h3, d};
  endfunction

  initial begin
    logic [8:0] q[$];
    logic [7:0] exp_seq [4];
    int sent, got, cyc;
    // reset state
    tick();
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_sel", 32'(out_sel), 0);
    chk_stats("rst_cnt");
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", 32'(in_ready), 1);
    // routing: 0x35 local, 0x55 forward, no bypass
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h35;
    #1;
    chk("no_bypass", 32'(out_valid), 0);
    tick();
    chk("rt0_valid", 32'(out_valid), 1);
    chk("rt0_data", 32'(out_data), 32'h35);
    chk("rt0_sel", 32'(out_sel), 0);
    in_data = 8'h55;
    tick();
    in_valid = 1'b0;
    chk("rt1_valid", 32'(out_valid), 1);
    chk("rt1_data", 32'(out_data), 32'h55);
    chk("rt1_sel", 32'(out_sel), 1);
    tick();
    chk("rt_empty_valid", 32'(out_valid), 0);
    chk("rt_empty_data", 32'(out_data), 0);
    exp_local = 1;
    exp_fwd = 1;
    chk_stats("rt_cnt");
    // fill under back-pressure
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1;
      in_data = 8'(i);
      #1;
      chk($sformatf("fill_rdy%0d", i), 32'(in_ready), (i <= 4) ? 1 : 0);
      tick();
      chk($sformatf("fill_head%0d", i), 32'(out_data), 32'h01);
    end
    chk("full_in_ready", 32'(in_ready), 0);
    // full with simultaneous pop: no push that cycle
    out_ready = 1'b1;
    tick();
    exp_fwd++;
    chk("fp_head", 32'(out_data), 32'h02);
    chk("fp_in_ready", 32'(in_ready), 1);
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("fp_refull", 32'(in_ready), 0);
    out_ready = 1'b1;
    exp_seq = '{8'h02, 8'h03, 8'h04, 8'h05};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_valid%0d", i), 32'(out_valid), 1);
      chk($sformatf("drain_data%0d", i), 32'(out_data), 32'(exp_seq[i]));
      chk($sformatf("drain_sel%0d", i), 32'(out_sel), 1);
      tick();
      exp_fwd++;
    end
    chk("drain_empty", 32'(out_valid), 0);
    chk_stats("drain_cnt");
    // wrap-around stream with random stalls against a queue model
    sent = 0;
    got = 0;
    cyc = 0;
    while (got < 12 && cyc < 300) begin
      in_valid = (sent < 12) && ($urandom_range(0, 3) != 0);
      in_data = 8'((sent % 5) * 16 + sent);
      out_ready = $urandom_range(0, 2) != 0;
      #1;
      chk("wr_in_ready", 32'(in_ready), (q.size() != 4) ? 1 : 0);
      chk("wr_out_valid", 32'(out_valid), (q.size() != 0) ? 1 : 0);
      if (out_valid && out_ready && q.size() != 0) begin
        chk("wr_out", 32'({out_sel, out_data}), 32'(q[0]));
        if (q[0][8]) exp_fwd++;
        else exp_local++;
        void'(q.pop_front());
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(entry(in_data));
        sent++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    chk("wr_delivered", 32'(got), 12);
    chk_stats("wr_cnt");
    // reset mid-stream with 3 entries held
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1;
      in_data = 8'(i * 16 + i);
      tick();
    end
    in_valid = 1'b0;
    chk("pre_rst_head", 32'(out_data), 32'h11);
    #2 rst = 1'b1;
    #1;
    exp_local = 0;
    exp_fwd = 0;
    chk("mrst_out_valid", 32'(out_valid), 0);
    chk("mrst_out_data", 32'(out_data), 0);
    chk("mrst_in_ready", 32'(in_ready), 0);
    chk_stats("mrst_cnt");
    tick();
    rst = 1'b0;
    tick();
    chk("mrst_after_ready", 32'(in_ready), 1);
    chk("mrst_after_valid", 32'(out_valid), 0);
    in_valid = 1'b1;
    in_data = 8'h3A;
    tick();
    in_valid = 1'b0;
    chk("post_push_valid", 32'(out_valid), 1);
    chk("post_push_data", 32'(out_data), 32'h3A);
    chk("post_push_sel", 32'(out_sel), 0);
    out_ready = 1'b1;
    tick();
    exp_local++;
    chk("post_pop_valid", 32'(out_valid), 0);
    chk_stats("end_cnt");
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/pe_route_sel.md
Name: pe_route_sel

Overview:
- Clocked ingress stage that sits directly upstream of the PE packet splitter.
- Accepts packets over a valid/ready handshake and buffers them in a small FIFO.
- Decodes each packet's destination field against the PE's local address and presents packet plus 1-bit select to the splitter (sel=0: local port R0, sel=1: forward port R1).
- Decouples the NoC link from PE back-pressure.

Parameters:
- WIDTH, 8, packet width in bits.
- ADDR_LSB, 4, LSB of destination field within packet.
- ADDR_W, 4, destination field width; ADDR_LSB+ADDR_W <= WIDTH.
- LOCAL_ADDR, 0, this PE's address, ADDR_W bits.
- DEPTH, 4, FIFO entries, power of two, >= 2.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream packet valid
- in_ready  output  1  block can accept a packet
- in_data  input  WIDTH  upstream packet
- out_valid  output  1  packet and select valid toward splitter
- out_ready  input  1  splitter accepts
- out_data  output  WIDTH  head packet
- out_sel  output  1  0 = local (R0), 1 = forward (R1)

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset (async assert, state held while rst=1):
  - write/read pointers = 0, occupancy count = 0.
  - in_ready = 0 while rst=1, then 1 from the first cycle after deassertion.
  - out_valid = 0, out_data = 0, out_sel = 0.
- Push: in_valid && in_ready at a rising edge.
  - Entry stored as {sel, in_data}.
  - sel = (in_data[ADDR_LSB +: ADDR_W] != LOCAL_ADDR), decided at enqueue.
- Pop: out_valid && out_ready at a rising edge; read pointer advances.
- in_ready = (count != DEPTH). It is combinational from registered count only, with no dependence on out_ready.
  - When full and a pop happens, a push is NOT accepted in the same cycle.
- out_valid = (count != 0).
  - out_data/out_sel show the head entry, driven from the registered read pointer.
  - Both read 0 when empty.
- Latency: a packet pushed into an empty FIFO appears on out_valid on the next cycle. There is no same-cycle bypass.
- Throughput: 1 packet/cycle when neither full nor stalled.
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
- Pointers are log2(DEPTH) bits and wrap naturally modulo DEPTH. count is log2(DEPTH)+1 bits.
- Stability: while out_valid && !out_ready, out_data/out_sel hold constant.
- No entry is ever dropped or reordered.
- Reset mid-operation: contents are discarded, with no partial output. The first post-reset push is delivered normally.
- in_valid while in_ready=0 is ignored and is not an error. Upstream holds data.

Optional Feature:
- Macro ROUTE_SEL_STATS_EN.
- When defined, adds outputs cnt_local [15:0] and cnt_fwd [15:0].
  - Each increments on a pop with out_sel=0 or 1 respectively.
  - Each wraps 16'hFFFF -> 0.
  - Both reset to 0.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package pe_pkg holds:
  - the packet typedef (logic [WIDTH-1:0]);
  - the route select enum (SEL_LOCAL=0, SEL_FWD=1);
  - ADDR_LSB/ADDR_W defaults, shared with the splitter and the merge stage.
- One natural sub-module: sync_fifo (parameterised width/depth, count-based full/empty), instantiated with width WIDTH+1.
- Address compare and stats stay in the top.

Test Plan:
- Reset: rst=1 mid-stream with 3 entries held → out_valid=0, out_data=0, in_ready=0 during reset and 1 in the cycle after deassert. With ROUTE_SEL_STATS_EN, counters are 0.
- Routing: LOCAL_ADDR=4'h3, push 8'h35 then 8'h55, out_ready=1 → out 8'h35/sel=0, then 8'h55/sel=1 on consecutive cycles, each 1 cycle after its push.
- Fill/back-pressure: out_ready=0, push 5 packets 8'h01..8'h05 with DEPTH=4 → first 4 accepted, in_ready=0 after the 4th, 8'h05 held upstream. out_data stays 8'h01.
- Full with simultaneous pop: full, in_valid=1, out_ready=1 for one cycle → 8'h01 popped, no push that cycle, 8'h05 accepted the next cycle. Order is 8'h02,03,04,05.
- Wrap-around: 3×DEPTH packets streamed with random out_ready stalls → output sequence equals input sequence, sel matches the address compare for each.
- Stats (macro on): 2 local and 3 forward packets popped → cnt_local=2, cnt_fwd=3. Preloading 16'hFFFF via force/long run then one local pop → 0.
